// File: rtl/vx_tensor_sequencer.sv
// Operand-gather / result-scatter sequencer between an issue slot and a tensor DPU array.
// Gathers BEATS operand beats into one wide request; serialises one wide result into BEATS commits.
module vx_tensor_sequencer #(
  parameter int unsigned LANES      = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned BEATS      = 2,
  parameter int unsigned META_W     = 64,
  parameter int unsigned META_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [3*LANES*XLEN-1:0]             in_data,
  input  logic [META_W-1:0]                   in_meta,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [BEATS*3*LANES*XLEN-1:0]       req_data,
  input  logic                                rsp_valid,
  output logic                                rsp_ready,
  input  logic [BEATS*LANES*XLEN-1:0]         rsp_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [LANES*XLEN-1:0]               out_data,
  output logic [META_W-1:0]                   out_meta,
  output logic                                out_last,
  output logic [$clog2(META_DEPTH+1)-1:0]     inflight
);

  localparam int unsigned WordW = LANES * XLEN;
  localparam int unsigned BeatW = 3 * WordW;
  localparam int unsigned PtrW  = $clog2(META_DEPTH);
  localparam int unsigned CntW  = $clog2(META_DEPTH + 1);
  localparam int unsigned BCntW = $clog2(BEATS);

  typedef enum logic {StGather, StIssue} gather_state_e;
  typedef enum logic {StEmpty, StDrain} scatter_state_e;

  gather_state_e           g_state_q, g_state_d;
  logic [BCntW-1:0]        g_cnt_q, g_cnt_d;
  logic [BEATS*BeatW-1:0]  g_buf_q;

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [META_W-1:0]       meta_mem_q [META_DEPTH];

  scatter_state_e          s_state_q, s_state_d;
  logic [BCntW-1:0]        s_cnt_q, s_cnt_d;
  logic [BEATS*WordW-1:0]  tile_q;

  logic meta_full, in_fire, req_fire, rsp_fire, out_fire;

  // Handshake outputs depend only on registered state, except rsp_ready's same-cycle drain term.
  assign meta_full = (cnt_q == CntW'(META_DEPTH));
  assign in_ready  = !reset && (g_state_q == StGather) && !meta_full;
  assign req_valid = !reset && (g_state_q == StIssue);
  assign out_valid = !reset && (s_state_q == StDrain);
  assign out_last  = (s_state_q == StDrain) && (s_cnt_q == BCntW'(BEATS - 1));
  assign rsp_ready = !reset && ((s_state_q == StEmpty) || (out_fire && out_last));

  assign in_fire  = in_valid && in_ready;
  assign req_fire = req_valid && req_ready;
  assign out_fire = out_valid && out_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  assign req_data = g_buf_q;
  assign out_meta = meta_mem_q[rd_ptr_q];
  assign inflight = cnt_q;

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (s_cnt_q == BCntW'(k)) out_data = tile_q[k*WordW +: WordW];
    end
  end

  always_comb begin
    g_state_d = g_state_q;
    g_cnt_d   = g_cnt_q;
    unique case (g_state_q)
      StGather: begin
        if (in_fire) begin
          if (g_cnt_q == BCntW'(BEATS - 1)) begin
            g_cnt_d   = '0;
            g_state_d = StIssue;
          end else begin
            g_cnt_d = g_cnt_q + BCntW'(1);
          end
        end
      end
      StIssue: begin
        if (req_fire) g_state_d = StGather;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (in_fire)  wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (out_fire) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (in_fire && !out_fire)      cnt_d = cnt_q + CntW'(1);
    else if (!in_fire && out_fire) cnt_d = cnt_q - CntW'(1);
  end

  // A tile load on the last drain beat takes priority and restarts at beat 0.
  always_comb begin
    s_state_d = s_state_q;
    s_cnt_d   = s_cnt_q;
    if (rsp_fire) begin
      s_state_d = StDrain;
      s_cnt_d   = '0;
    end else if (out_fire) begin
      if (out_last) begin
        s_state_d = StEmpty;
        s_cnt_d   = '0;
      end else begin
        s_cnt_d = s_cnt_q + BCntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g_state_q <= StGather;
      g_cnt_q   <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      s_state_q <= StEmpty;
      s_cnt_q   <= '0;
    end else begin
      g_state_q <= g_state_d;
      g_cnt_q   <= g_cnt_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      s_state_q <= s_state_d;
      s_cnt_q   <= s_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (in_fire && (g_cnt_q == BCntW'(k))) g_buf_q[k*BeatW +: BeatW] <= in_data;
    end
    if (in_fire)  meta_mem_q[wr_ptr_q] <= in_meta;
    if (rsp_fire) tile_q <= rsp_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(rsp_fire && (cnt_q < CntW'(BEATS))));
      assert (!(out_valid && (cnt_q == '0)));
    end
  end

endmodule

// File: tb/tb_vx_tensor_sequencer.sv
// Bench for vx_tensor_sequencer: directed vector table, multi-cycle corner cases and a
// randomized run against a queue-based reference model.
module tb_vx_tensor_sequencer;

  localparam int LANES  = 4;
  localparam int XLEN   = 16;
  localparam int BEATS  = 2;
  localparam int META_W = 16;
  localparam int DEPTH  = 16;
  localparam int SDEPTH = 4;
  localparam int WORD_W = LANES * XLEN;
  localparam int IN_W   = 3 * WORD_W;
  localparam int REQ_W  = BEATS * IN_W;
  localparam int RSP_W  = BEATS * WORD_W;
  localparam int CW     = REQ_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              in_valid, in_ready, req_valid, req_ready, rsp_valid, rsp_ready;
  logic              out_valid, out_ready, out_last;
  logic [IN_W-1:0]   in_data;
  logic [META_W-1:0] in_meta, out_meta;
  logic [REQ_W-1:0]  req_data;
  logic [RSP_W-1:0]  rsp_data;
  logic [WORD_W-1:0] out_data;
  logic [4:0]        inflight;

  logic              s_in_valid, s_in_ready, s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready;
  logic              s_out_valid, s_out_ready, s_out_last;
  logic [IN_W-1:0]   s_in_data;
  logic [META_W-1:0] s_in_meta, s_out_meta;
  logic [REQ_W-1:0]  s_req_data;
  logic [RSP_W-1:0]  s_rsp_data;
  logic [WORD_W-1:0] s_out_data;
  logic [2:0]        s_inflight;

  vx_tensor_sequencer #(
    .LANES(LANES), .XLEN(XLEN), .BEATS(BEATS), .META_W(META_W), .META_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_meta(in_meta),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_meta(out_meta),
    .out_last(out_last), .inflight(inflight)
  );

  // Shallow-FIFO instance for the backpressure-on-full scenario.
  vx_tensor_sequencer #(
    .LANES(LANES), .XLEN(XLEN), .BEATS(BEATS), .META_W(META_W), .META_DEPTH(SDEPTH)
  ) dut_small (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_meta(s_in_meta),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_data(s_req_data),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_meta(s_out_meta), .out_last(s_out_last), .inflight(s_inflight)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        in_valid;
    logic [15:0] in_w, in_meta;
    logic        req_ready, rsp_valid;
    logic [15:0] rsp_w0, rsp_w1;
    logic        out_ready;
    logic        e_in_ready, e_req_valid;
    logic [15:0] e_req_w0, e_req_w1;
    logic        e_rsp_ready, e_out_valid;
    logic [15:0] e_out_w, e_out_meta;
    logic        e_out_last;
    int          e_inflight;
  } vec_t;

  vec_t vecs[7];

  logic [META_W-1:0] m_meta[$];
  logic [IN_W-1:0]   m_grp[$];
  logic [WORD_W-1:0] m_tile[$];
  bit                m_issue;
  int                m_owed;
  logic              e_in_ready, e_req_valid, e_out_valid, e_rsp_ready;
  logic              f_in, f_req, f_out, f_rsp;
  logic [REQ_W-1:0]  e_req;
  int                fired;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rep_in(input logic [XLEN-1:0] w);
    return {(3 * LANES){w}};
  endfunction

  function automatic logic [WORD_W-1:0] rep_word(input logic [XLEN-1:0] w);
    return {LANES{w}};
  endfunction

  function automatic vec_t mkv(input logic iv, input logic [15:0] iw, im,
                               input logic rr, rv, input logic [15:0] r0, r1, input logic orr,
                               input logic eir, erv, input logic [15:0] ew0, ew1,
                               input logic erp, eov, input logic [15:0] eow, eom,
                               input logic eol, input int einf);
    vec_t v;
    v.in_valid = iv;   v.in_w = iw;      v.in_meta = im;
    v.req_ready = rr;  v.rsp_valid = rv; v.rsp_w0 = r0;  v.rsp_w1 = r1;  v.out_ready = orr;
    v.e_in_ready = eir; v.e_req_valid = erv; v.e_req_w0 = ew0; v.e_req_w1 = ew1;
    v.e_rsp_ready = erp; v.e_out_valid = eov; v.e_out_w = eow; v.e_out_meta = eom;
    v.e_out_last = eol; v.e_inflight = einf;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; in_meta = '0; req_ready = 0; rsp_valid = 0; rsp_data = '0;
    out_ready = 0;
    s_in_valid = 0; s_in_data = '0; s_in_meta = '0; s_req_ready = 0; s_rsp_valid = 0;
    s_rsp_data = '0; s_out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic push_beat(input logic [15:0] w, input logic [15:0] meta);
    bit done = 0;
    in_valid = 1;
    in_data  = rep_in(w);
    in_meta  = meta;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 0;
    check("push_accepted", CW'(done), CW'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = mkv(1, 16'h1111, 1, 0, 0, 0, 0, 1,  1, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    vecs[1] = mkv(1, 16'h2222, 2, 0, 0, 0, 0, 1,  1, 0, 0, 0,  1, 0, 0, 0, 0, 1);
    vecs[2] = mkv(0, 0, 0, 1, 0, 0, 0, 1,  0, 1, 16'h1111, 16'h2222,  1, 0, 0, 0, 0, 2);
    vecs[3] = mkv(0, 0, 0, 0, 1, 16'hAAAA, 16'hBBBB, 1,  1, 0, 0, 0,  1, 0, 0, 0, 0, 2);
    vecs[4] = mkv(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0,  0, 1, 16'hAAAA, 1, 0, 2);
    vecs[5] = mkv(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0,  1, 1, 16'hBBBB, 2, 1, 1);
    vecs[6] = mkv(0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0,  1, 0, 0, 0, 0, 0);

    // Directed table: one gather/issue/scatter round trip.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid  = vecs[i].in_valid;
      in_data   = rep_in(vecs[i].in_w);
      in_meta   = vecs[i].in_meta;
      req_ready = vecs[i].req_ready;
      rsp_valid = vecs[i].rsp_valid;
      rsp_data  = {rep_word(vecs[i].rsp_w1), rep_word(vecs[i].rsp_w0)};
      out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("vec%0d_in_ready", i), CW'(in_ready), CW'(vecs[i].e_in_ready));
      check($sformatf("vec%0d_req_valid", i), CW'(req_valid), CW'(vecs[i].e_req_valid));
      if (vecs[i].e_req_valid)
        check($sformatf("vec%0d_req_data", i), CW'(req_data),
              CW'({rep_in(vecs[i].e_req_w1), rep_in(vecs[i].e_req_w0)}));
      check($sformatf("vec%0d_rsp_ready", i), CW'(rsp_ready), CW'(vecs[i].e_rsp_ready));
      check($sformatf("vec%0d_out_valid", i), CW'(out_valid), CW'(vecs[i].e_out_valid));
      if (vecs[i].e_out_valid) begin
        check($sformatf("vec%0d_out_data", i), CW'(out_data), CW'(rep_word(vecs[i].e_out_w)));
        check($sformatf("vec%0d_out_meta", i), CW'(out_meta), CW'(vecs[i].e_out_meta));
        check($sformatf("vec%0d_out_last", i), CW'(out_last), CW'(vecs[i].e_out_last));
      end
      check($sformatf("vec%0d_inflight", i), CW'(inflight), CW'(vecs[i].e_inflight));
      tick();
    end

    // req_ready held low for 5 cycles while new beats are offered.
    do_reset();
    in_valid = 1; in_data = rep_in(16'h3333); in_meta = 3;
    #1 check("stall_b0_ready", CW'(in_ready), CW'(1));
    tick();
    in_data = rep_in(16'h4444); in_meta = 4;
    #1 check("stall_b1_ready", CW'(in_ready), CW'(1));
    tick();
    for (int i = 0; i < 5; i++) begin
      in_data = rep_in(16'h9000 + 16'(i));
      #1;
      check("stall_in_ready", CW'(in_ready), CW'(0));
      check("stall_req_valid", CW'(req_valid), CW'(1));
      check("stall_req_data", CW'(req_data), CW'({rep_in(16'h4444), rep_in(16'h3333)}));
      tick();
    end
    req_ready = 1;
    #1 check("stall_fire_valid", CW'(req_valid), CW'(1));
    tick();
    req_ready = 0; in_data = rep_in(16'h5555); in_meta = 5;
    #1;
    check("stall_resume_ready", CW'(in_ready), CW'(1));
    check("stall_resume_reqv", CW'(req_valid), CW'(0));
    check("stall_resume_infl", CW'(inflight), CW'(2));
    tick();
    in_valid = 0;
    #1 check("stall_after_push", CW'(inflight), CW'(3));

    // Three back-to-back tiles with rsp_valid held high.
    do_reset();
    req_ready = 1;
    for (int i = 0; i < 6; i++) push_beat(16'h1000 + 16'(i), 16'(10 + i));
    tick();
    #1;
    check("b2b_gathered_infl", CW'(inflight), CW'(6));
    check("b2b_gathered_reqv", CW'(req_valid), CW'(0));
    rsp_valid = 1; rsp_data = {rep_word(16'hA001), rep_word(16'hA000)}; out_ready = 1;
    #1 check("b2b_first_rsp_ready", CW'(rsp_ready), CW'(1));
    tick();
    fired = 1;
    for (int j = 0; j < 6; j++) begin
      rsp_valid = (fired < 3);
      rsp_data  = {rep_word(16'hA001 + 16'(fired * 16)), rep_word(16'hA000 + 16'(fired * 16))};
      #1;
      check("b2b_out_valid", CW'(out_valid), CW'(1));
      check("b2b_out_data", CW'(out_data), CW'(rep_word(16'hA000 + 16'((j / 2) * 16 + j % 2))));
      check("b2b_out_meta", CW'(out_meta), CW'(10 + j));
      check("b2b_out_last", CW'(out_last), CW'(j % 2));
      check("b2b_rsp_ready", CW'(rsp_ready), CW'(j % 2));
      if (j % 2 == 1 && fired < 3) fired++;
      tick();
    end
    rsp_valid = 0;
    #1;
    check("b2b_end_valid", CW'(out_valid), CW'(0));
    check("b2b_end_infl", CW'(inflight), CW'(0));

    // Shallow FIFO fills and blocks dispatch until the tile drains.
    do_reset();
    s_req_ready = 1; s_in_valid = 1; fired = 0;
    for (int n = 0; n < 20 && fired < 4; n++) begin
      s_in_data = rep_in(16'h7000 + 16'(fired));
      s_in_meta = 16'(fired);
      #1;
      if (s_in_ready) fired++;
      tick();
    end
    check("full_push_count", CW'(fired), CW'(4));
    s_in_valid = 0;
    tick();
    #1;
    check("full_in_ready", CW'(s_in_ready), CW'(0));
    check("full_req_valid", CW'(s_req_valid), CW'(0));
    check("full_inflight", CW'(s_inflight), CW'(4));
    s_in_valid = 1;
    s_rsp_valid = 1; s_rsp_data = {rep_word(16'hC1C1), rep_word(16'hC0C0)};
    #1;
    check("full_rsp_ready", CW'(s_rsp_ready), CW'(1));
    check("full_hold_ready", CW'(s_in_ready), CW'(0));
    tick();
    s_in_valid = 0; s_rsp_valid = 0; s_out_ready = 1;
    #1;
    check("full_out0_valid", CW'(s_out_valid), CW'(1));
    check("full_out0_meta", CW'(s_out_meta), CW'(0));
    check("full_out0_ready", CW'(s_in_ready), CW'(0));
    tick();
    #1 check("full_out1_last", CW'(s_out_last), CW'(1));
    tick();
    s_out_ready = 0;
    #1;
    check("full_reassert", CW'(s_in_ready), CW'(1));
    check("full_after_infl", CW'(s_inflight), CW'(2));
    check("full_after_valid", CW'(s_out_valid), CW'(0));

    // Reset after one beat discards the partial group.
    do_reset();
    in_valid = 1; in_data = rep_in(16'h7777); in_meta = 7;
    #1 check("rst_beat0_ready", CW'(in_ready), CW'(1));
    tick();
    reset = 1; rsp_valid = 1; out_ready = 1; req_ready = 1;
    #1;
    check("rst_in_ready", CW'(in_ready), CW'(0));
    check("rst_req_valid", CW'(req_valid), CW'(0));
    check("rst_rsp_ready", CW'(rsp_ready), CW'(0));
    check("rst_out_valid", CW'(out_valid), CW'(0));
    tick();
    reset = 0; in_valid = 0; rsp_valid = 0; req_ready = 0;
    #1;
    check("rst_post_infl", CW'(inflight), CW'(0));
    check("rst_post_reqv", CW'(req_valid), CW'(0));
    tick();
    push_beat(16'h5555, 8);
    push_beat(16'h6666, 9);
    #1;
    check("rst_fresh_reqv", CW'(req_valid), CW'(1));
    check("rst_fresh_data", CW'(req_data), CW'({rep_in(16'h6666), rep_in(16'h5555)}));
    check("rst_fresh_infl", CW'(inflight), CW'(2));

    // Randomized traffic against the queue model.
    do_reset();
    m_meta.delete(); m_grp.delete(); m_tile.delete(); m_issue = 0; m_owed = 0;
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < IN_W / 32; k++) in_data[k*32 +: 32] = $urandom();
      in_meta   = META_W'($urandom());
      req_ready = ($urandom_range(0, 2) != 0);
      out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rsp_valid = (m_owed > 0) && ($urandom_range(0, 1) == 1);
      for (int k = 0; k < RSP_W / 32; k++) rsp_data[k*32 +: 32] = $urandom();
      #1;
      e_in_ready  = !m_issue && (m_meta.size() < DEPTH);
      e_req_valid = m_issue;
      e_out_valid = (m_tile.size() > 0);
      e_rsp_ready = (m_tile.size() == 0) || (out_ready && m_tile.size() == 1);
      e_req = '0;
      for (int k = 0; k < m_grp.size(); k++) e_req[k*IN_W +: IN_W] = m_grp[k];
      check("rnd_in_ready", CW'(in_ready), CW'(e_in_ready));
      check("rnd_req_valid", CW'(req_valid), CW'(e_req_valid));
      if (e_req_valid) check("rnd_req_data", CW'(req_data), CW'(e_req));
      check("rnd_rsp_ready", CW'(rsp_ready), CW'(e_rsp_ready));
      check("rnd_out_valid", CW'(out_valid), CW'(e_out_valid));
      if (e_out_valid) begin
        check("rnd_out_data", CW'(out_data), CW'(m_tile[0]));
        check("rnd_out_meta", CW'(out_meta), CW'(m_meta[0]));
        check("rnd_out_last", CW'(out_last), CW'(m_tile.size() == 1));
      end
      check("rnd_inflight", CW'(inflight), CW'(m_meta.size()));
      f_in  = in_valid && e_in_ready;
      f_req = req_ready && e_req_valid;
      f_out = out_ready && e_out_valid;
      f_rsp = rsp_valid && e_rsp_ready;
      if (f_out) begin
        void'(m_tile.pop_front());
        void'(m_meta.pop_front());
      end
      if (f_rsp) begin
        for (int k = 0; k < BEATS; k++) m_tile.push_back(rsp_data[k*WORD_W +: WORD_W]);
        m_owed--;
      end
      if (f_req) begin
        m_grp.delete();
        m_issue = 0;
        m_owed++;
      end
      if (f_in) begin
        m_meta.push_back(in_meta);
        m_grp.push_back(in_data);
        if (m_grp.size() == BEATS) m_issue = 1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
